// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle CPU datapath.
// Sequences fetch/decode/execute/memory/writeback, handshakes with a
// variable-latency unified memory through memReady, and counts retired
// instructions.
//
//  state      | meaning
//  -----------+----------------------------------------------
//  S_INIT     | post-reset idle, all outputs low, go to fetch
//  S_FETCH    | read instruction at PC, PC+1, wait on memory
//  S_DECODE   | latch opcode, precompute branch target
//  S_EXEC_R   | R-type ALU operation (regA op regB)
//  S_WB_R     | write ALU result to rd
//  S_EXEC_I   | immediate ALU operation (regA op imm)
//  S_WB_I     | write ALU result to rt
//  S_MEM_ADDR | compute load/store address
//  S_MEM_RD   | data read, wait on memory
//  S_WB_MEM   | write MDR to rt
//  S_MEM_WR   | data write, wait on memory
//  S_BRANCH   | compare and conditionally load branch target
//  S_JUMP     | load jump target
//  S_HALT     | parked until reset
module multicycle_control #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [3:0]       opcode_i,
    input  logic             memReady_i,
    output logic             pcWrite_o,
    output logic             pcWriteCond_o,
    output logic             iorD_o,
    output logic             memRead_o,
    output logic             memWrite_o,
    output logic             irWrite_o,
    output logic             memToReg_o,
    output logic             regDst_o,
    output logic             regWrite_o,
    output logic             aluSrcA_o,
    output logic [1:0]       aluSrcB_o,
    output logic [1:0]       pcSource_o,
    output logic [2:0]       aluOp_o,
    output logic             illegalOp_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] instRetired_o
);

    localparam logic [3:0] OP_R    = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_ANDI = 4'h2;
    localparam logic [3:0] OP_ORI  = 4'h3;
    localparam logic [3:0] OP_SLTI = 4'h4;
    localparam logic [3:0] OP_LW   = 4'h5;
    localparam logic [3:0] OP_SW   = 4'h6;
    localparam logic [3:0] OP_BEQ  = 4'h7;
    localparam logic [3:0] OP_J    = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [3:0] {
        S_INIT, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I,
        S_MEM_ADDR, S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_HALT
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;
    logic [2:0]       imm_alu_op;

    // ALU operation for immediate instructions, chosen by the latched opcode
    always_comb begin
        case (op_q)
            OP_ANDI: imm_alu_op = 3'b010;
            OP_ORI:  imm_alu_op = 3'b011;
            OP_SLTI: imm_alu_op = 3'b100;
            default: imm_alu_op = 3'b000;
        endcase
    end

    // Next state, datapath controls and retirement strobe
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        retire        = 1'b0;
        pcWrite_o     = 1'b0;
        pcWriteCond_o = 1'b0;
        iorD_o        = 1'b0;
        memRead_o     = 1'b0;
        memWrite_o    = 1'b0;
        irWrite_o     = 1'b0;
        memToReg_o    = 1'b0;
        regDst_o      = 1'b0;
        regWrite_o    = 1'b0;
        aluSrcA_o     = 1'b0;
        aluSrcB_o     = 2'b00;
        pcSource_o    = 2'b00;
        aluOp_o       = 3'b000;
        illegalOp_o   = 1'b0;
        halted_o      = 1'b0;
        case (state_q)
            S_INIT: state_d = S_FETCH;
            S_FETCH: begin
                memRead_o = 1'b1;
                aluSrcB_o = 2'b01;
                // IR and PC are only loaded on the cycle the memory delivers
                irWrite_o = memReady_i;
                pcWrite_o = memReady_i;
                if (memReady_i) state_d = S_DECODE;
            end
            S_DECODE: begin
                aluSrcB_o = 2'b11;
                op_d      = opcode_i;
                case (opcode_i)
                    OP_R:                             state_d = S_EXEC_R;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_EXEC_I;
                    OP_LW, OP_SW:                     state_d = S_MEM_ADDR;
                    OP_BEQ:                           state_d = S_BRANCH;
                    OP_J:                             state_d = S_JUMP;
                    OP_HALT: begin
                        state_d = S_HALT;
                        retire  = 1'b1;
                    end
                    default: begin
                        illegalOp_o = 1'b1;
                        state_d     = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: begin
                aluSrcA_o = 1'b1;
                aluOp_o   = 3'b111;
                state_d   = S_WB_R;
            end
            S_WB_R: begin
                regDst_o   = 1'b1;
                regWrite_o = 1'b1;
                aluOp_o    = 3'b111;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_EXEC_I: begin
                aluSrcA_o = 1'b1;
                aluSrcB_o = 2'b10;
                aluOp_o   = imm_alu_op;
                state_d   = S_WB_I;
            end
            S_WB_I: begin
                regWrite_o = 1'b1;
                aluOp_o    = imm_alu_op;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_ADDR: begin
                aluSrcA_o = 1'b1;
                aluSrcB_o = 2'b10;
                state_d   = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                memRead_o = 1'b1;
                iorD_o    = 1'b1;
                if (memReady_i) state_d = S_WB_MEM;
            end
            S_WB_MEM: begin
                regWrite_o = 1'b1;
                memToReg_o = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                memWrite_o = 1'b1;
                iorD_o     = 1'b1;
                if (memReady_i) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_BRANCH: begin
                aluSrcA_o     = 1'b1;
                aluOp_o       = 3'b001;
                pcWriteCond_o = 1'b1;
                pcSource_o    = 2'b01;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pcWrite_o  = 1'b1;
                pcSource_o = 2'b10;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_HALT: halted_o = 1'b1;
            default: state_d = S_INIT;
        endcase
    end

    // Retired-instruction counter wraps naturally at 2^CNT_W
    always_comb begin
        cnt_d = cnt_q;
        if (retire) cnt_d = cnt_q + CNT_W'(1);
    end

    // State, opcode latch and counter registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_INIT;
            op_q    <= 4'h0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    assign instRetired_o = cnt_q;

endmodule
